// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a UART TX FIFO. Grants are held for
// a packet or up to MAX_BURST bytes; every state update is qualified by s_tick.
module uart_tx_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick,
    input  logic                 req0_valid,
    input  logic [DATA_SIZE-1:0] req0_data,
    input  logic                 req0_last,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_SIZE-1:0] req1_data,
    input  logic                 req1_last,
    output logic                 req1_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [DATA_SIZE-1:0] fifo_wdata,
    output logic [1:0]           grant,
    output logic                 busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             grant_q, grant_d;
    logic                   busy_q, busy_d;

    logic                   own_valid_s;
    logic                   own_last_s;
    logic [DATA_SIZE-1:0]   own_data_s;
    logic                   xfer_s;
    logic [CW-1:0]          cnt_inc_s;

    // Select the current owner's request signals.
    always_comb begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        own_data_s  = {DATA_SIZE{1'b0}};
        case (state_q)
            GNT0: begin
                own_valid_s = req0_valid;
                own_last_s  = req0_last;
                own_data_s  = req0_data;
            end
            GNT1: begin
                own_valid_s = req1_valid;
                own_last_s  = req1_last;
                own_data_s  = req1_data;
            end
            default: begin
                own_valid_s = 1'b0;
                own_last_s  = 1'b0;
                own_data_s  = {DATA_SIZE{1'b0}};
            end
        endcase
    end

    // Handshake and FIFO write path; data passes straight through unregistered.
    always_comb begin
        req0_ready = (state_q == GNT0) & s_tick & ~fifo_full;
        req1_ready = (state_q == GNT1) & s_tick & ~fifo_full;
        xfer_s     = own_valid_s & s_tick & ~fifo_full;
        fifo_wr    = xfer_s;
        fifo_wdata = own_data_s;
        cnt_inc_s  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

    // Next-state, round-robin pointer and burst counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (s_tick) begin
            case (state_q)
                IDLE: begin
                    if (req0_valid && (!req1_valid || !ptr_q)) begin
                        state_d = GNT0;
                        cnt_d   = {CW{1'b0}};
                    end else if (req1_valid) begin
                        state_d = GNT1;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                GNT0, GNT1: begin
                    if (!own_valid_s) begin
                        state_d = IDLE;
                        ptr_d   = (state_q == GNT0);
                    end else if (xfer_s) begin
                        cnt_d = cnt_inc_s;
                        if (own_last_s || (cnt_inc_s == CW'(MAX_BURST))) begin
                            state_d = IDLE;
                            ptr_d   = (state_q == GNT0);
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        // FIFO full: owner keeps the grant, count frozen
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        grant_d = state_d;
        busy_d  = (state_d != IDLE);
    end

    // State register with registered grant/busy decodes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, expected
// FIFO writes and grant changes are queued per scenario and compared on output.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       fifo_full, fifo_wr;
    logic [7:0] fifo_wdata;
    logic [1:0] grant;
    logic       busy;

    uart_tx_arbiter #(.DATA_SIZE(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tick     (s_tick),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tick_div = 1;
    int wr_cnt = 0;
    int rel_wr = -1;
    int gnt_rise_cyc = -1;
    int first_wr_cyc = -1;
    logic [1:0] prev_gnt = 2'b00;
    logic       prev_tick = 1'b0;
    logic       prev_wr = 1'b0;
    logic [1:0] smp_gnt;
    logic       smp_rdy0;

    // {last, data} per requester; {owner, data} for expected writes
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_wr_q[$];
    logic [1:0] exp_gnt_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic [8:0] e;
        logic [1:0] g;
        @(negedge clk);
        s_tick     = (tick_div == 1) ? 1'b1 : ((cyc % tick_div) == (tick_div - 1));
        req0_valid = (q0.size() > 0);
        req0_data  = req0_valid ? q0[0][7:0] : 8'h00;
        req0_last  = req0_valid ? q0[0][8] : 1'b0;
        req1_valid = (q1.size() > 0);
        req1_data  = req1_valid ? q1[0][7:0] : 8'h00;
        req1_last  = req1_valid ? q1[0][8] : 1'b0;
        #1;
        smp_gnt  = grant;
        smp_rdy0 = req0_ready;
        if (fifo_wr) begin
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            check_eq("wr_qual", 32'({s_tick, fifo_full}), 32'h2);
            if (tick_div > 1) check_eq("wr_width", 32'(prev_wr), 32'h0);
            if (exp_wr_q.size() == 0) begin
                check_eq("wr_extra", 32'(exp_wr_q.size()), 32'h1);
            end else begin
                e = exp_wr_q.pop_front();
                check_eq("wr_data", 32'(fifo_wdata), 32'(e[7:0]));
                check_eq("wr_owner", 32'(grant), e[8] ? 32'h2 : 32'h1);
            end
        end
        if (req0_ready) check_eq("rdy0_own", 32'({s_tick, fifo_full, grant}), 32'h9);
        if (req1_ready) check_eq("rdy1_own", 32'({s_tick, fifo_full, grant}), 32'hA);
        if (grant !== prev_gnt) begin
            check_eq("gnt_on_tick", 32'(prev_tick), 32'h1);
            check_eq("busy", 32'(busy), 32'(|grant));
            if (exp_gnt_q.size() == 0) begin
                check_eq("gnt_extra", 32'(exp_gnt_q.size()), 32'h1);
            end else begin
                g = exp_gnt_q.pop_front();
                check_eq("grant", 32'(grant), 32'(g));
            end
            if (grant != 2'b00 && gnt_rise_cyc < 0) gnt_rise_cyc = cyc;
            if (grant == 2'b00 && rel_wr < 0) rel_wr = wr_cnt;
            prev_gnt = grant;
        end
        if (req0_valid && req0_ready) void'(q0.pop_front());
        if (req1_valid && req1_ready) void'(q1.pop_front());
        prev_tick = s_tick;
        prev_wr   = fifo_wr;
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        s_tick  = 1'b1;
        #1;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_wr", 32'(fifo_wr), 32'h0);
        check_eq("rst_wdata", 32'(fifo_wdata), 32'h0);
        check_eq("rst_rdy", 32'({req0_ready, req1_ready}), 32'h0);
        prev_gnt = 2'b00;
        q0.delete();
        q1.delete();
        @(posedge clk);
        cyc++;
        repeat (2) cycle();
        check_eq("rst_hold_grant", 32'(smp_gnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic start_scn();
        wr_cnt = 0;
        rel_wr = -1;
        gnt_rise_cyc = -1;
        first_wr_cyc = -1;
    endtask

    task automatic run_until_done(input int bound);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + exp_wr_q.size() + exp_gnt_q.size()) != 0 && n < bound) begin
            cycle();
            n++;
        end
        check_eq("done_in_time", 32'(n < bound), 32'h1);
        repeat (3) cycle();
    endtask

    task automatic run_until_wr(input int target, input int bound);
        int n;
        n = 0;
        while (wr_cnt < target && n < bound) begin
            cycle();
            n++;
        end
        check_eq("wr_wait", 32'(wr_cnt), 32'(target));
    endtask

    initial begin
        reset_n = 1'b0;
        s_tick = 1'b0;
        fifo_full = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        do_reset();

        // Single requester, two-byte packet
        start_scn();
        q0 = '{9'h041, 9'h142};
        exp_wr_q = '{9'h041, 9'h042};
        exp_gnt_q = '{2'b01, 2'b00};
        run_until_done(200);
        check_eq("lat_one_tick", 32'(first_wr_cyc), 32'(gnt_rise_cyc));
        check_eq("a_burst_len", 32'(rel_wr), 32'h2);

        // Pointer now 1: simultaneous requests go to req1 first
        start_scn();
        q0 = '{9'h1C0};
        q1 = '{9'h1C1};
        exp_wr_q = '{9'h1C1, 9'h0C0};
        exp_gnt_q = '{2'b10, 2'b00, 2'b01, 2'b00};
        run_until_done(200);

        // Contention from reset: whole packets, no interleaving
        do_reset();
        start_scn();
        q0 = '{9'h0A0, 9'h0A1, 9'h1A2};
        q1 = '{9'h0B0, 9'h0B1, 9'h1B2};
        exp_wr_q = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1B0, 9'h1B1, 9'h1B2};
        exp_gnt_q = '{2'b01, 2'b00, 2'b10, 2'b00};
        run_until_done(200);

        // Burst limit: req1 streams, req0 joins once req1 owns the FIFO
        start_scn();
        q1 = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015};
        exp_wr_q = '{9'h110, 9'h111, 9'h112, 9'h113, 9'h055, 9'h114, 9'h115};
        exp_gnt_q = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 50 && prev_gnt != 2'b10; i++) cycle();
        q0 = '{9'h155};
        run_until_done(200);
        check_eq("c_burst_len", 32'(rel_wr), 32'h4);

        // Backpressure mid-burst: grant held, count frozen
        start_scn();
        q0 = '{9'h060, 9'h061, 9'h062, 9'h063, 9'h164};
        exp_wr_q = '{9'h060, 9'h061, 9'h062, 9'h063, 9'h064};
        exp_gnt_q = '{2'b01, 2'b00, 2'b01, 2'b00};
        run_until_wr(2, 100);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("bp_grant", 32'(smp_gnt), 32'h1);
            check_eq("bp_ready", 32'(smp_rdy0), 32'h0);
        end
        check_eq("bp_no_wr", 32'(wr_cnt), 32'h2);
        fifo_full = 1'b0;
        run_until_done(200);
        check_eq("d_burst_len", 32'(rel_wr), 32'h4);

        // Sparse tick: activity only in s_tick cycles (pointer is 1)
        start_scn();
        tick_div = 16;
        q0 = '{9'h070, 9'h171};
        q1 = '{9'h180};
        exp_wr_q = '{9'h180, 9'h070, 9'h071};
        exp_gnt_q = '{2'b10, 2'b00, 2'b01, 2'b00};
        run_until_done(2000);
        tick_div = 1;

        // Reset after 2 of 4 bytes
        do_reset();
        start_scn();
        q0 = '{9'h090, 9'h091, 9'h092, 9'h193};
        exp_wr_q = '{9'h090, 9'h091};
        exp_gnt_q = '{2'b01};
        run_until_wr(2, 100);
        do_reset();
        repeat (3) cycle();
        check_eq("f_wr_count", 32'(wr_cnt), 32'h2);
        check_eq("f_exp_left", 32'(exp_wr_q.size() + exp_gnt_q.size()), 32'h0);

        // Pointer back at 0 after reset
        start_scn();
        q0 = '{9'h1A5};
        q1 = '{9'h1B5};
        exp_wr_q = '{9'h0A5, 9'h1B5};
        exp_gnt_q = '{2'b01, 2'b00, 2'b10, 2'b00};
        run_until_done(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
